instruction_ram_loader: RTL and testbench
=========================================

Name: instruction_ram_loader

Overview:
- Writer-side counterpart to the boot instruction memory: receives a Hack program as a byte stream from the serial receiver and writes it as 16-bit words into the writable instruction RAM.
- The RAM is read later by the CPU at `instruction = RAM[pc]`.
- Sits between the UART receiver (byte valid strobe) and the instruction RAM write port; the bootloader triggers it with `start`.
- Reports completion, word count and error status.

Parameters:
- ADDR_WIDTH, 12, word-address width of instruction RAM write port.
- DEPTH, 4096, maximum number of words accepted (must be ≤ 2^ADDR_WIDTH).
- TIMEOUT_CYCLES, 1000000, max idle clocks between bytes while loading before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when not busy.
- rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  input  8  received byte.
- ram_we  output  1  one-cycle write enable to instruction RAM.
- ram_addr  output  ADDR_WIDTH  word write address.
- ram_data  output  16  word write data.
- busy  output  1  high while a load is in progress.
- done  output  1  high after a successful load, until next start or reset.
- error  output  1  high after an aborted load, until next start or reset.
- err_code  output  2  0 none, 1 checksum mismatch, 2 length > DEPTH, 3 timeout.
- words_loaded  output  16  words written in current/last load.

Behaviour:
- Reset (async, rst_n low) values:
  - All outputs 0.
  - State IDLE.
  - Length, word counter, checksum accumulator and timeout counter cleared.
  - A reset mid-load abandons the load immediately; RAM contents already written are left as-is.
- Frame format, bytes in order:
  - LEN_HI, LEN_LO: word count N, big-endian.
  - N words, each MSB byte then LSB byte.
  - CHK: 8-bit modular sum of all preceding frame bytes, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR.
- IDLE/DONE/ERR:
  - rx_valid is ignored.
  - On start: go to LEN_HI; clear done, error, err_code, words_loaded, checksum and timeout counter; set busy.
- LEN_HI: byte → len[15:8] → LEN_LO.
- LEN_LO: byte → len[7:0], then:
  - N > DEPTH → ERR, err_code 2.
  - N = 0 → CHK.
  - Otherwise → DATA_HI.
- DATA_HI: byte stored as high byte → DATA_LO.
- DATA_LO, on the byte:
  - Write is registered: in the next cycle ram_we = 1 for exactly one cycle, ram_addr = words_loaded (pre-increment), ram_data = {hi, byte}.
  - words_loaded increments in the same cycle as ram_we.
  - If the incremented count = N → CHK, else → DATA_HI.
- CHK: byte compared with accumulated sum.
  - Equal → DONE.
  - Unequal → ERR, err_code 1.
  - The CHK byte is not added to the sum.
- Checksum accumulation: 8-bit add with wrap, updated on every accepted byte before CHK.
- Timeout:
  - Counter runs in LEN_HI..CHK and resets to 0 on every rx_valid.
  - Reaching TIMEOUT_CYCLES → ERR, err_code 3.
- Throughput: rx_valid may be asserted on consecutive cycles; no byte may be dropped.
- start while busy is ignored.
- Entering DONE or ERR clears busy and sets done or error in the same cycle as the state change.
- done and error are never high together.
- ram_addr and ram_data hold their last values when ram_we = 0.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 00 03 12 34 AB CD 00 07 C8.
  - Response: three ram_we pulses writing addr0=0x1234, addr1=0xABCD, addr2=0x0007; then done=1, words_loaded=3, busy=0, error=0.
- Empty program:
  - Stimulus: start, then bytes 00 00 00.
  - Response: no ram_we; done=1, words_loaded=0.
- Bad checksum:
  - Stimulus: same frame as the normal load but CHK=0xC9.
  - Response: three writes occur; then error=1, err_code=1, done=0.
- Oversize length:
  - Stimulus: start, then bytes 10 01 (N=4097).
  - Response: error=1, err_code=2; no ram_we; later bytes ignored.
- Timeout:
  - Stimulus: with TIMEOUT_CYCLES=50, start, bytes 00 02 12, then silence.
  - Response: error=1, err_code=3 exactly 50 cycles after the last byte; no ram_we.
- Reset mid-load and back-to-back bytes:
  - Stimulus: assert rst_n=0 after 5 frame bytes; then start and deliver a valid frame with rx_valid high on consecutive cycles.
  - Response: all outputs 0 during reset; the second frame loads completely and done=1.

Source files
------------

// File: rtl/instruction_ram_loader.sv
// +-----------------------------------------------------------------------------+
// | instruction_ram_loader: writes a framed byte stream into instruction RAM    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module instruction_ram_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [15:0]           words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      c_depth    = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHK     = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_len, w_len_nxt;
  logic [7:0]            r_hi, w_hi_nxt;
  logic [7:0]            r_sum, w_sum_nxt;
  logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;
  logic [15:0]           w_words_nxt, w_words_inc;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [15:0]           w_data_nxt;
  logic                  w_busy_nxt, w_done_nxt, w_error_nxt;
  logic [1:0]            w_code_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_hi         <= '0;
      r_sum        <= '0;
      r_tmo        <= '0;
      words_loaded <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_hi         <= w_hi_nxt;
      r_sum        <= w_sum_nxt;
      r_tmo        <= w_tmo_nxt;
      words_loaded <= w_words_nxt;
      ram_we       <= w_we_nxt;
      ram_addr     <= w_addr_nxt;
      ram_data     <= w_data_nxt;
      busy         <= w_busy_nxt;
      done         <= w_done_nxt;
      error        <= w_error_nxt;
      err_code     <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_hi_nxt    = r_hi;
    w_sum_nxt   = r_sum;
    w_tmo_nxt   = r_tmo;
    w_words_nxt = words_loaded;
    w_words_inc = words_loaded + 16'd1;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = ram_addr;
    w_data_nxt  = ram_data;
    w_busy_nxt  = busy;
    w_done_nxt  = done;
    w_error_nxt = error;
    w_code_nxt  = err_code;

    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_state_nxt = LEN_HI;
          w_sum_nxt   = '0;
          w_tmo_nxt   = '0;
          w_words_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_code_nxt  = 2'd0;
        end
      end
      default: begin
        if (rx_valid) begin
          w_tmo_nxt = '0;
          // The checksum byte itself never enters the running sum.
          if (r_state != CHK) w_sum_nxt = r_sum + rx_data;
          case (r_state)
            LEN_HI: begin
              w_len_nxt   = {rx_data, r_len[7:0]};
              w_state_nxt = LEN_LO;
            end
            LEN_LO: begin
              w_len_nxt = {r_len[15:8], rx_data};
              if ({1'b0, w_len_nxt} > c_depth) begin
                w_state_nxt = ERR;
                w_busy_nxt  = 1'b0;
                w_error_nxt = 1'b1;
                w_code_nxt  = 2'd2;
              end else if (w_len_nxt == 16'd0) begin
                w_state_nxt = CHK;
              end else begin
                w_state_nxt = DATA_HI;
              end
            end
            DATA_HI: begin
              w_hi_nxt    = rx_data;
              w_state_nxt = DATA_LO;
            end
            DATA_LO: begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = words_loaded[ADDR_WIDTH-1:0];
              w_data_nxt  = {r_hi, rx_data};
              w_words_nxt = w_words_inc;
              w_state_nxt = (w_words_inc == r_len) ? CHK : DATA_HI;
            end
            CHK: begin
              w_busy_nxt = 1'b0;
              if (rx_data == r_sum) begin
                w_state_nxt = DONE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ERR;
                w_error_nxt = 1'b1;
                w_code_nxt  = 2'd1;
              end
            end
            default: ;
          endcase
        end else if (r_tmo == c_tmo_last) begin
          w_state_nxt = ERR;
          w_busy_nxt  = 1'b0;
          w_error_nxt = 1'b1;
          w_code_nxt  = 2'd3;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_ram_loader.sv
// +-----------------------------------------------------------------------------+
// | tb_instruction_ram_loader: directed bench for instruction_ram_loader        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int n_vec = 0;
  int n_bad = 0;

  instruction_ram_loader #(
    .ADDR_WIDTH(12),
    .DEPTH(4096),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        rv;
    logic [7:0]  rd;
    logic        we;
    logic [11:0] addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  code;
    logic [15:0] words;
  } vec_t;

  vec_t tbl[$];
  logic [27:0] wq[$];

  always @(negedge clk) if (ram_we) wq.push_back({ram_addr, ram_data});

  function automatic vec_t v(logic s, logic rv, logic [7:0] rd, logic we, logic [11:0] a,
                             logic [15:0] d, logic b, logic dn, logic er, logic [1:0] c,
                             logic [15:0] w);
    vec_t r;
    r.start = s; r.rv = rv; r.rd = rd; r.we = we; r.addr = a; r.data = d;
    r.busy = b; r.done = dn; r.error = er; r.code = c; r.words = w;
    return r;
  endfunction

  task automatic check_outs(string name, vec_t e);
    n_vec++;
    if (ram_we !== e.we || ram_addr !== e.addr || ram_data !== e.data || busy !== e.busy ||
        done !== e.done || error !== e.error || err_code !== e.code || words_loaded !== e.words) begin
      n_bad++;
      $display("FAIL %s: got we=%0b addr=%h data=%h busy=%0b done=%0b err=%0b code=%0d words=%0d, want we=%0b addr=%h data=%h busy=%0b done=%0b err=%0b code=%0d words=%0d",
               name, ram_we, ram_addr, ram_data, busy, done, error, err_code, words_loaded,
               e.we, e.addr, e.data, e.busy, e.done, e.error, e.code, e.words);
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    vec_t zero;
    zero = v(0,0,8'h00, 0,12'h0,16'h0000, 0,0,0,2'd0,16'd0);

    // Normal load, with a start ignored mid-load and one idle gap
    tbl.push_back(v(1,0,8'h00, 0,12'h0,16'h0000, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h0,16'h0000, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(1,1,8'h03, 0,12'h0,16'h0000, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h12, 0,12'h0,16'h0000, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h34, 1,12'h0,16'h1234, 1,0,0,2'd0,16'd1));
    tbl.push_back(v(0,1,8'hAB, 0,12'h0,16'h1234, 1,0,0,2'd0,16'd1));
    tbl.push_back(v(0,1,8'hCD, 1,12'h1,16'hABCD, 1,0,0,2'd0,16'd2));
    tbl.push_back(v(0,0,8'h00, 0,12'h1,16'hABCD, 1,0,0,2'd0,16'd2));
    tbl.push_back(v(0,1,8'h00, 0,12'h1,16'hABCD, 1,0,0,2'd0,16'd2));
    tbl.push_back(v(0,1,8'h07, 1,12'h2,16'h0007, 1,0,0,2'd0,16'd3));
    tbl.push_back(v(0,1,8'hC8, 0,12'h2,16'h0007, 0,1,0,2'd0,16'd3));
    tbl.push_back(v(0,1,8'h55, 0,12'h2,16'h0007, 0,1,0,2'd0,16'd3));
    // Empty program
    tbl.push_back(v(1,0,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h2,16'h0007, 0,1,0,2'd0,16'd0));
    // Bad checksum
    tbl.push_back(v(1,0,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h03, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h12, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h34, 1,12'h0,16'h1234, 1,0,0,2'd0,16'd1));
    tbl.push_back(v(0,1,8'hAB, 0,12'h0,16'h1234, 1,0,0,2'd0,16'd1));
    tbl.push_back(v(0,1,8'hCD, 1,12'h1,16'hABCD, 1,0,0,2'd0,16'd2));
    tbl.push_back(v(0,1,8'h00, 0,12'h1,16'hABCD, 1,0,0,2'd0,16'd2));
    tbl.push_back(v(0,1,8'h07, 1,12'h2,16'h0007, 1,0,0,2'd0,16'd3));
    tbl.push_back(v(0,1,8'hC9, 0,12'h2,16'h0007, 0,0,1,2'd1,16'd3));
    // Oversize length (4097), trailing byte ignored
    tbl.push_back(v(1,0,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h10, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h01, 0,12'h2,16'h0007, 0,0,1,2'd2,16'd0));
    tbl.push_back(v(0,1,8'h12, 0,12'h2,16'h0007, 0,0,1,2'd2,16'd0));
    // Length exactly DEPTH is accepted
    tbl.push_back(v(1,0,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h10, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));
    tbl.push_back(v(0,1,8'h00, 0,12'h2,16'h0007, 1,0,0,2'd0,16'd0));

    #12;
    check_outs("reset_state", zero);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      start    = tbl[i].start;
      rx_valid = tbl[i].rv;
      rx_data  = tbl[i].rd;
      @(posedge clk); #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      check_outs($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset mid-load after five frame bytes, then a back-to-back frame
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send(8'h00); send(8'h02); send(8'hAA); send(8'hBB); send(8'hCC);
    rst_n = 1'b0;
    #1;
    check_outs("reset_async", zero);
    rx_valid = 1'b1; rx_data = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    check_outs("reset_hold", zero);
    rx_valid = 1'b0; start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    pulse_start();
    send(8'h00); send(8'h02); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h3A);
    check_outs("b2b_done", v(0,0,8'h00, 0,12'h1,16'hBEEF, 0,1,0,2'd0,16'd2));
    n_vec++;
    if (wq.size() != 2 || wq[0] !== {12'h0, 16'hDEAD} || wq[1] !== {12'h1, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL b2b_writes: got %0d writes (first=%h), want 2 writes 000dead,001beef",
               wq.size(), (wq.size() > 0) ? wq[0] : 28'h0);
    end

    // Timeout: error exactly 50 cycles after the last byte
    wq.delete();
    pulse_start();
    send(8'h00); send(8'h02); send(8'h12);
    n = 0;
    while (!error && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (n != 50 || err_code !== 2'd3 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout: got cycles=%0d code=%0d busy=%0b done=%0b, want cycles=50 code=3 busy=0 done=0",
               n, err_code, busy, done);
    end
    n_vec++;
    if (wq.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_no_write: got %0d writes, want 0", wq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
